// File: rtl/debounce_edge_detect.sv
// Debounces a synchronous input with a four-state qualify FSM and
// emits registered rise/fall pulses plus a wrapping transition count.
module debounce_edge_detect #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             cnt_clr,
  output logic             dout,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic             busy,
  output logic [CNT_W-1:0] edge_count
);

  localparam int QW = $clog2(STABLE_CYCLES);
  localparam logic [QW-1:0] LAST = QW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    STABLE_HI,
    CHECK_LO,
    STABLE_LO,
    CHECK_HI
  } state_t;

  state_t          state, state_n;
  logic [QW-1:0]   qcnt, qcnt_n;
  logic            dout_n;
  logic            rise_n, fall_n;
  logic            acc;
  logic [CNT_W-1:0] cnt_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= STABLE_HI;
      qcnt       <= '0;
      dout       <= 1'b1;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      edge_count <= '0;
    end else begin
      state      <= state_n;
      qcnt       <= qcnt_n;
      dout       <= dout_n;
      rise_pulse <= rise_n;
      fall_pulse <= fall_n;
      edge_count <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    qcnt_n  = qcnt;
    dout_n  = dout;
    rise_n  = 1'b0;
    fall_n  = 1'b0;
    acc     = 1'b0;
    unique case (state)
      STABLE_HI: begin
        if (!din) begin
          state_n = CHECK_LO;
          qcnt_n  = QW'(1);
        end
      end
      CHECK_LO: begin
        if (din) begin
          state_n = STABLE_HI;
          qcnt_n  = '0;
        end else if (qcnt == LAST) begin
          state_n = STABLE_LO;
          qcnt_n  = '0;
          dout_n  = 1'b0;
          fall_n  = 1'b1;
          acc     = 1'b1;
        end else begin
          qcnt_n = qcnt + QW'(1);
        end
      end
      STABLE_LO: begin
        if (din) begin
          state_n = CHECK_HI;
          qcnt_n  = QW'(1);
        end
      end
      CHECK_HI: begin
        if (!din) begin
          state_n = STABLE_LO;
          qcnt_n  = '0;
        end else if (qcnt == LAST) begin
          state_n = STABLE_HI;
          qcnt_n  = '0;
          dout_n  = 1'b1;
          rise_n  = 1'b1;
          acc     = 1'b1;
        end else begin
          qcnt_n = qcnt + QW'(1);
        end
      end
    endcase
  end

  // A clear that lands on an acceptance still records that transition.
  always_comb begin
    if (cnt_clr)
      cnt_n = acc ? CNT_W'(1) : '0;
    else
      cnt_n = edge_count + CNT_W'(acc);
  end

  assign busy = (state == CHECK_LO) || (state == CHECK_HI);

endmodule

// File: tb/tb_debounce_edge_detect.sv
// Directed and random checks of debounce_edge_detect against a
// run-length reference model.
module tb_debounce_edge_detect;

  localparam int SC = 4;
  localparam int CW = 8;
  localparam int MOD = 1 << CW;

  logic          clk = 1'b0;
  logic          reset;
  logic          din;
  logic          cnt_clr;
  logic          dout;
  logic          rise_pulse;
  logic          fall_pulse;
  logic          busy;
  logic [CW-1:0] edge_count;

  int total  = 0;
  int passed = 0;

  bit m_dout;
  bit m_rise;
  bit m_fall;
  int m_run;
  int m_cnt;
  int rnd_pulses;

  debounce_edge_detect #(
    .STABLE_CYCLES(SC),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .din(din),
    .cnt_clr(cnt_clr),
    .dout(dout),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .busy(busy),
    .edge_count(edge_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_dout = 1'b1;
    m_rise = 1'b0;
    m_fall = 1'b0;
    m_run  = 0;
    m_cnt  = 0;
  endtask

  // Level flips after SC consecutive samples that differ from it.
  task automatic model_step(input bit d, input bit c);
    bit acc;
    acc    = 1'b0;
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (d != m_dout) begin
      m_run++;
      if (m_run == SC) begin
        m_dout = d;
        m_rise = d;
        m_fall = !d;
        m_run  = 0;
        acc    = 1'b1;
      end
    end else begin
      m_run = 0;
    end
    if (c) m_cnt = acc ? 1 : 0;
    else   m_cnt = (m_cnt + int'(acc)) % MOD;
    rnd_pulses += int'(m_rise) + int'(m_fall);
  endtask

  task automatic compare();
    check("dout", 32'(dout), 32'(m_dout));
    check("rise", 32'(rise_pulse), 32'(m_rise));
    check("fall", 32'(fall_pulse), 32'(m_fall));
    check("busy", 32'(busy), 32'(m_run != 0));
    check("count", 32'(edge_count), 32'(m_cnt));
    check("excl", 32'(rise_pulse & fall_pulse), 32'd0);
  endtask

  task automatic tick(input logic d, input logic c);
    din     = d;
    cnt_clr = c;
    @(posedge clk);
    model_step(d, c);
    #1;
    compare();
  endtask

  initial begin
    bit d;
    int n;
    int len;
    reset   = 1'b1;
    din     = 1'b1;
    cnt_clr = 1'b0;
    rnd_pulses = 0;
    model_reset();
    #2;
    check("rst_dout", 32'(dout), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cnt", 32'(edge_count), 32'd0);
    check("rst_rise", 32'(rise_pulse), 32'd0);
    check("rst_fall", 32'(fall_pulse), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // clean fall
    repeat (3) begin
      tick(1'b0, 1'b0);
      check("fall_busy", 32'(busy), 32'd1);
      check("fall_hold", 32'(dout), 32'd1);
    end
    tick(1'b0, 1'b0);
    check("fall_dout", 32'(dout), 32'd0);
    check("fall_pulse", 32'(fall_pulse), 32'd1);
    check("fall_cnt", 32'(edge_count), 32'd1);
    tick(1'b0, 1'b0);
    check("fall_once", 32'(fall_pulse), 32'd0);
    tick(1'b0, 1'b0);

    // round trip back high
    repeat (3) tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    check("rise_pulse", 32'(rise_pulse), 32'd1);
    check("rise_cnt", 32'(edge_count), 32'd2);
    repeat (2) tick(1'b1, 1'b0);

    // glitch reject
    repeat (3) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    check("glitch_dout", 32'(dout), 32'd1);
    check("glitch_busy", 32'(busy), 32'd0);
    check("glitch_cnt", 32'(edge_count), 32'd2);

    // wrap and clear
    tick(1'b1, 1'b1);
    check("clr_cnt", 32'(edge_count), 32'd0);
    d = 1'b1;
    for (int i = 0; i < 256; i++) begin
      d = ~d;
      repeat (SC) tick(d, 1'b0);
    end
    check("wrap_cnt", 32'(edge_count), 32'd0);
    check("wrap_dout", 32'(dout), 32'd1);
    repeat (SC - 1) tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    check("clr_acc_cnt", 32'(edge_count), 32'd1);
    check("clr_acc_dout", 32'(dout), 32'd0);

    // async reset mid-qualification, din low afterwards
    repeat (SC) tick(1'b1, 1'b0);
    repeat (2) tick(1'b0, 1'b0);
    check("pre_rst_busy", 32'(busy), 32'd1);
    #3 reset = 1'b1;
    #1;
    model_reset();
    check("arst_dout", 32'(dout), 32'd1);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_cnt", 32'(edge_count), 32'd0);
    #1 reset = 1'b0;
    repeat (SC - 1) begin
      tick(1'b0, 1'b0);
      check("post_rst_nofall", 32'(fall_pulse), 32'd0);
    end
    tick(1'b0, 1'b0);
    check("post_rst_dout", 32'(dout), 32'd0);
    check("post_rst_fall", 32'(fall_pulse), 32'd1);
    check("post_rst_cnt", 32'(edge_count), 32'd1);

    // random stream
    tick(1'b0, 1'b1);
    rnd_pulses = 0;
    n = 0;
    while (n < 10000) begin
      d   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 2 * SC);
      repeat (len) tick(d, 1'b0);
      n += len;
    end
    check("rnd_cnt", 32'(edge_count), 32'(rnd_pulses % MOD));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/debounce_edge_detect.md
DEBOUNCE_EDGE_DETECT -- requirements
Module: debounce_edge_detect

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4: consecutive differing samples needed to accept a level change; legal range 2..65535.
REQ-002 SHALL have parameter CNT_W, default 8: width of the transition event counter.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port din, input, 1: registered bit from the upstream master-slave flip-flop output; treated as already synchronous to clk.
REQ-006 SHALL have port cnt_clr, input, 1: synchronous clear of edge_count.
REQ-007 SHALL have port dout, output, 1: debounced level.
REQ-008 SHALL have port rise_pulse, output, 1: one-cycle pulse on each debounced 0->1 change.
REQ-009 SHALL have port fall_pulse, output, 1: one-cycle pulse on each debounced 1->0 change.
REQ-010 SHALL have port busy, output, 1: high while a candidate change is being qualified.
REQ-011 SHALL have port edge_count, output, CNT_W: count of accepted debounced transitions, both directions.

Function
REQ-012 SHALL implement a four-state FSM: STABLE_HI, CHECK_LO, STABLE_LO, CHECK_HI.
REQ-013 SHALL use a qualification counter of ceil(log2(STABLE_CYCLES)) bits, zero in both STABLE states.
REQ-014 In STABLE_HI, a sampled din=0 SHALL move to CHECK_LO with counter=1; din=1 SHALL hold the state. STABLE_LO mirrors this with CHECK_HI.
REQ-015 In CHECK_LO, a sampled din=1 SHALL abort to STABLE_HI, clear the counter, and leave dout unchanged, with no pulse and no count. CHECK_HI mirrors this.
REQ-016 In CHECK_LO, din=0 with counter<STABLE_CYCLES-1 SHALL increment the counter.
REQ-017 In CHECK_LO, din=0 with counter=STABLE_CYCLES-1 SHALL move to STABLE_LO, set dout=0, clear the counter, and assert fall_pulse.
REQ-018 CHECK_HI SHALL behave symmetrically: on acceptance, move to STABLE_HI, set dout=1, and assert rise_pulse.
REQ-019 Latency SHALL be as follows: dout changes on the STABLE_CYCLES-th consecutive rising edge that samples the new din value.
REQ-020 rise_pulse and fall_pulse SHALL be registered, high for exactly the cycle after the edge where dout changes, and never high together.
REQ-021 A din glitch shorter than STABLE_CYCLES samples SHALL produce no dout change, no pulse, and no count.
REQ-022 busy SHALL equal 1 exactly in CHECK_LO and CHECK_HI.
REQ-023 edge_count SHALL increment by 1 on each accepted transition and wrap from 2^CNT_W-1 to 0 with no flag.
REQ-024 On cnt_clr=1 with no accepted transition, edge_count SHALL become 0 on that edge.
REQ-025 On cnt_clr=1 coinciding with an accepted transition, edge_count SHALL become 1.
REQ-026 dout SHALL be driven only from a flop, never combinationally from din.

Reset
REQ-027 While reset=1, outputs SHALL be forced immediately, independent of clk: state=STABLE_HI, counter=0, dout=1 (matching the upstream flip-flop reset value of 1), rise_pulse=0, fall_pulse=0, busy=0, edge_count=0.
REQ-028 Assertion of reset mid-qualification SHALL discard the pending candidate and pulse. After release, the first edge SHALL be evaluated from STABLE_HI.
REQ-029 If din=0 at reset release, dout SHALL fall after STABLE_CYCLES consecutive low samples, with fall_pulse and edge_count=1.

Verification (STABLE_CYCLES=4, CNT_W=8)
REQ-030 Clean fall: reset, then din=0 held -> dout=0 on the 4th sampling edge, fall_pulse high 1 cycle, edge_count=1, busy high for 3 cycles.
REQ-031 Glitch reject: from stable high, din=0 for 3 samples then 1 -> dout stays 1, no pulses, edge_count unchanged, busy drops on the 4th edge.
REQ-032 Round trip: fall then rise, each held 6 cycles -> one fall_pulse, then one rise_pulse 6 cycles later, edge_count=2.
REQ-033 Wrap and clear: 256 accepted transitions -> edge_count=0; cnt_clr on the edge of the next acceptance -> edge_count=1.
REQ-034 Async reset mid-check: reset pulsed between clk edges in CHECK_LO at counter=2 -> dout=1, busy=0 immediately; pending fall never appears.
REQ-035 Pulse exclusivity: a random din toggle stream for 10k cycles -> rise_pulse&fall_pulse never 1, and edge_count equals total pulses mod 256.
